// File: rtl/prbs_stream_checker.sv
// rtl/prbs_stream_checker.sv - PRBS-31 stream checker with self-synchronising reference and saturating error counters
// Optional feature macro: PRBS_STREAM_CHECKER_ERROR_MASK_EN (exposes error_mask)
module prbs_stream_checker #(
    parameter int WIDTH        = 32,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4,
    parameter int COUNT_WIDTH  = 48
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [WIDTH-1:0]       S_AXIS_TDATA,
    input  logic                   S_AXIS_TVALID,
    output logic                   S_AXIS_TREADY,
    input  logic                   clear,
    input  logic                   resync,
    output logic                   locked,
    output logic [COUNT_WIDTH-1:0] bit_error_count,
    output logic [COUNT_WIDTH-1:0] word_error_count,
    output logic [COUNT_WIDTH-1:0] word_count
`ifdef PRBS_STREAM_CHECKER_ERROR_MASK_EN
    ,
    output logic [WIDTH-1:0]       error_mask
`endif
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);
    localparam int PW = $clog2(WIDTH + 1);
    localparam int SW = COUNT_WIDTH + PW;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] prev, prev_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] next_w;
    logic [GW-1:0]    good_cnt, good_d;
    logic [BW-1:0]    bad_cnt, bad_d;
    logic             chk_vld, chk_vld_d;
    logic [PW-1:0]    pop;

    assign S_AXIS_TREADY = 1'b1;
    assign locked        = (state == ST_LOCKED);
`ifdef PRBS_STREAM_CHECKER_ERROR_MASK_EN
    assign error_mask    = mask_q;
`endif

    function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                       input logic [PW-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s > SW'({COUNT_WIDTH{1'b1}}))
            return {COUNT_WIDTH{1'b1}};
        return s[COUNT_WIDTH-1:0];
    endfunction

    // Extend prev by WIDTH PRBS bits; taps past bit 30 reuse bits of the word being built.
    always_comb begin : next_word_calc
        logic [2*WIDTH-1:0] ext;
        ext = {{WIDTH{1'b0}}, prev};
        for (int i = WIDTH; i < 2 * WIDTH; i++)
            ext[i] = ext[i-31] ^ ext[i-28];
        next_w = ext[2*WIDTH-1:WIDTH];
    end

    // Lock state machine next-state; in LOCKED the reference free-runs so errors never enter it.
    always_comb begin
        state_d   = state;
        prev_d    = prev;
        good_d    = good_cnt;
        bad_d     = bad_cnt;
        mask_d    = mask_q;
        chk_vld_d = 1'b0;
        if (resync) begin
            state_d = ST_UNLOCKED;
            good_d  = '0;
            bad_d   = '0;
            if (S_AXIS_TVALID)
                mask_d = '0;
        end else if (S_AXIS_TVALID) begin
            case (state)
                ST_UNLOCKED: begin
                    prev_d  = S_AXIS_TDATA;
                    good_d  = '0;
                    mask_d  = '0;
                    state_d = ST_LOCKING;
                end
                ST_LOCKING: begin
                    prev_d = S_AXIS_TDATA;
                    mask_d = '0;
                    if (S_AXIS_TDATA == next_w && S_AXIS_TDATA[30:0] != 31'd0) begin
                        good_d = good_cnt + GW'(1);
                        if (good_cnt == GW'(LOCK_COUNT - 1)) begin
                            state_d = ST_LOCKED;
                            bad_d   = '0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    prev_d    = next_w;
                    mask_d    = S_AXIS_TDATA ^ next_w;
                    chk_vld_d = 1'b1;
                    if ((S_AXIS_TDATA ^ next_w) != '0) begin
                        bad_d = bad_cnt + BW'(1);
                        if (bad_cnt == BW'(UNLOCK_COUNT - 1))
                            state_d = ST_UNLOCKED;
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
    end

    // Stage 1 registers: state, reference, mask and the pending-count flag.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state    <= ST_UNLOCKED;
            prev     <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            mask_q   <= '0;
            chk_vld  <= 1'b0;
        end else begin
            state    <= state_d;
            prev     <= prev_d;
            good_cnt <= good_d;
            bad_cnt  <= bad_d;
            mask_q   <= mask_d;
            chk_vld  <= chk_vld_d;
        end
    end

    // Population count of the registered mask for the stage-2 bit counter.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++)
            pop = pop + PW'(mask_q[i]);
    end

    // Stage 2: saturating statistics; clear overrides any update on the same edge.
    always_ff @(posedge clk) begin
        if (!aresetn || clear) begin
            bit_error_count  <= '0;
            word_error_count <= '0;
            word_count       <= '0;
        end else if (chk_vld) begin
            bit_error_count  <= sat_add(bit_error_count, pop);
            word_error_count <= sat_add(word_error_count, PW'(mask_q != '0));
            word_count       <= sat_add(word_count, PW'(1));
        end
    end

endmodule

// File: tb/tb_prbs_stream_checker.sv
// tb/tb_prbs_stream_checker.sv - self-checking bench for prbs_stream_checker
module tb_prbs_stream_checker;

    localparam int W  = 32;
    localparam int LC = 8;
    localparam int UC = 4;
    localparam int M_UNL = 0, M_LKG = 1, M_LKD = 2;

    logic        clk = 1'b0;
    logic        aresetn, tvalid, clear, resync;
    logic [31:0] tdata;
    logic        tready1, tready2, locked1, locked2;
    logic [47:0] bec1, wec1, wc1;
    logic [3:0]  bec2, wec2, wc2;
`ifdef PRBS_STREAM_CHECKER_ERROR_MASK_EN
    logic [31:0] em1, em2;
    logic [31:0] m_em;
`endif

    always #5 clk = ~clk;

    prbs_stream_checker #(.WIDTH(W), .LOCK_COUNT(LC), .UNLOCK_COUNT(UC), .COUNT_WIDTH(48)) dut1 (
        .clk(clk), .aresetn(aresetn), .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid),
        .S_AXIS_TREADY(tready1), .clear(clear), .resync(resync), .locked(locked1),
        .bit_error_count(bec1), .word_error_count(wec1), .word_count(wc1)
`ifdef PRBS_STREAM_CHECKER_ERROR_MASK_EN
        , .error_mask(em1)
`endif
    );

    prbs_stream_checker #(.WIDTH(W), .LOCK_COUNT(LC), .UNLOCK_COUNT(UC), .COUNT_WIDTH(4)) dut2 (
        .clk(clk), .aresetn(aresetn), .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid),
        .S_AXIS_TREADY(tready2), .clear(clear), .resync(resync), .locked(locked2),
        .bit_error_count(bec2), .word_error_count(wec2), .word_count(wc2)
`ifdef PRBS_STREAM_CHECKER_ERROR_MASK_EN
        , .error_mask(em2)
`endif
    );

    int checks = 0;
    int failures = 0;

    // reference model state
    int          m_state;
    logic [31:0] m_prev;
    int          m_good, m_bad;
    bit          p_vld;
    logic [31:0] p_mask;
    longint      t_wc, t_wec, t_bec;
    logic [31:0] gen_w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Next WIDTH sequence bits after word w, grown one bit at a time from the recurrence.
    function automatic logic [31:0] prbs_next(input logic [31:0] w);
        bit q[$];
        logic [31:0] r;
        for (int i = 0; i < 32; i++) q.push_back(w[i]);
        for (int i = 0; i < 32; i++) begin
            q.push_back(q[q.size()-31] ^ q[q.size()-28]);
            r[i] = q[q.size()-1];
        end
        return r;
    endfunction

    function automatic logic [63:0] sat15(input longint t);
        return (t > 15) ? 64'd15 : 64'(t);
    endfunction

    task automatic model_edge(input logic rn, input logic v, input logic [31:0] d,
                              input logic c, input logic r);
        logic [31:0] e, mk;
        if (!rn) begin
            m_state = M_UNL; m_prev = '0; m_good = 0; m_bad = 0;
            p_vld = 0; p_mask = '0; t_wc = 0; t_wec = 0; t_bec = 0;
`ifdef PRBS_STREAM_CHECKER_ERROR_MASK_EN
            m_em = '0;
`endif
            return;
        end
        if (c) begin
            t_wc = 0; t_wec = 0; t_bec = 0;
        end else if (p_vld) begin
            t_wc++;
            if (p_mask != 0) t_wec++;
            t_bec += $countones(p_mask);
        end
        p_vld = 0;
        if (r) begin
            m_state = M_UNL; m_good = 0; m_bad = 0;
`ifdef PRBS_STREAM_CHECKER_ERROR_MASK_EN
            if (v) m_em = '0;
`endif
        end else if (v) begin
            mk = '0;
            if (m_state == M_UNL) begin
                m_prev = d; m_good = 0; m_state = M_LKG;
            end else if (m_state == M_LKG) begin
                if (d == prbs_next(m_prev) && d[30:0] != 0) begin
                    m_good++;
                    if (m_good == LC) begin m_state = M_LKD; m_bad = 0; end
                end else m_good = 0;
                m_prev = d;
            end else begin
                e = prbs_next(m_prev);
                mk = d ^ e;
                m_prev = e;
                p_vld = 1; p_mask = mk;
                if (mk != 0) begin
                    m_bad++;
                    if (m_bad == UC) m_state = M_UNL;
                end else m_bad = 0;
            end
`ifdef PRBS_STREAM_CHECKER_ERROR_MASK_EN
            m_em = mk;
`endif
        end
    endtask

    task automatic compare_all();
        chk("locked1", 64'(locked1), 64'(m_state == M_LKD));
        chk("locked2", 64'(locked2), 64'(m_state == M_LKD));
        chk("wc1", 64'(wc1), 64'(t_wc));
        chk("wec1", 64'(wec1), 64'(t_wec));
        chk("bec1", 64'(bec1), 64'(t_bec));
        chk("wc2", 64'(wc2), sat15(t_wc));
        chk("wec2", 64'(wec2), sat15(t_wec));
        chk("bec2", 64'(bec2), sat15(t_bec));
`ifdef PRBS_STREAM_CHECKER_ERROR_MASK_EN
        chk("em1", 64'(em1), 64'(m_em));
        chk("em2", 64'(em2), 64'(m_em));
`endif
    endtask

    task automatic step(input logic rn, input logic v, input logic [31:0] d,
                        input logic c, input logic r);
        aresetn = rn; tvalid = v; tdata = d; clear = c; resync = r;
        @(posedge clk);
        model_edge(rn, v, d, c, r);
        #1;
        compare_all();
    endtask

    task automatic send(input logic [31:0] x, input logic r);
        step(1'b1, 1'b1, gen_w ^ x, 1'b0, r);
        gen_w = prbs_next(gen_w);
    endtask

    typedef struct {
        string       name;
        bit          pre_resync;
        bit          zero_data;
        int          nwords;
        int          err_first;
        int          err_last;
        int          hole_end;
        logic [31:0] err_mask;
        bit          exp_locked;
        longint      exp_wc, exp_wec, exp_bec;
        int          exp_rise, exp_fall;
    } phase_t;

    phase_t ph[5];

    initial begin
        ph[0] = '{"clean100", 0, 0, 100, -1, -1, 0, 32'h0, 1, 91, 0, 0, 8, -1};
        ph[1] = '{"single_err", 0, 0, 60, 50, 50, 0, 32'h0000_0101, 1, 60, 1, 2, -1, -1};
        ph[2] = '{"unlock4", 0, 0, 20, 5, 8, 0, 32'h1, 1, 11, 4, 4, 17, 8};
        ph[3] = '{"all_zero", 1, 1, 50, -1, -1, 0, 32'h0, 0, 0, 0, 0, -1, -1};
        ph[4] = '{"saturate", 0, 0, 58, 30, 57, 54, 32'hFFFF_FFFF, 0, 49, 22, 704, 8, 57};

        gen_w = 32'h7FFF_FFFF;
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("tready1", 64'(tready1), 64'd1);
        chk("tready2", 64'(tready2), 64'd1);
        chk("reset_locked", 64'(locked1), 64'd0);
        chk("reset_wc", 64'(wc1), 64'd0);

        for (int p = 0; p < 5; p++) begin
            int rise, fall;
            rise = -1; fall = -1;
            step(1'b1, 1'b0, '0, 1'b1, ph[p].pre_resync);
            for (int i = 0; i < ph[p].nwords; i++) begin
                logic l0;
                logic [31:0] x;
                l0 = locked1;
                x = '0;
                if (i >= ph[p].err_first && i <= ph[p].err_last &&
                    !(i < ph[p].hole_end && (i - ph[p].err_first) % 4 == 3))
                    x = ph[p].err_mask;
                if (ph[p].zero_data) step(1'b1, 1'b1, '0, 1'b0, 1'b0);
                else send(x, 1'b0);
                if (!l0 && locked1 && rise < 0) rise = i;
                if (l0 && !locked1 && fall < 0) fall = i;
            end
            step(1'b1, 1'b0, '0, 1'b0, 1'b0);
            step(1'b1, 1'b0, '0, 1'b0, 1'b0);
            chk({ph[p].name, "_locked"}, 64'(locked1), 64'(ph[p].exp_locked));
            chk({ph[p].name, "_wc"}, 64'(wc1), 64'(ph[p].exp_wc));
            chk({ph[p].name, "_wec"}, 64'(wec1), 64'(ph[p].exp_wec));
            chk({ph[p].name, "_bec"}, 64'(bec1), 64'(ph[p].exp_bec));
            chk({ph[p].name, "_rise"}, 64'(rise), 64'(ph[p].exp_rise));
            chk({ph[p].name, "_fall"}, 64'(fall), 64'(ph[p].exp_fall));
        end
        chk("sat_bec2", 64'(bec2), 64'hF);
        chk("sat_wec2", 64'(wec2), 64'hF);
        chk("sat_wc2", 64'(wc2), 64'hF);

        // clear on the edge that would add an errored word
        for (int i = 0; i < 12; i++) send('0, 1'b0);
        chk("relock", 64'(locked1), 64'd1);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        send(32'h3, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("clear_wc", 64'(wc1), 64'd0);
        chk("clear_wec", 64'(wec1), 64'd0);
        chk("clear_bec", 64'(bec1), 64'd0);
        chk("clear_locked", 64'(locked1), 64'd1);
        // resync with a coincident word: unlocks and the word is not counted
        send('0, 1'b1);
        chk("resync_locked", 64'(locked1), 64'd0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("resync_wc", 64'(wc1), 64'd0);

        // reset while an errored word is in flight to stage 2
        for (int i = 0; i < 10; i++) send('0, 1'b0);
        send(32'hF0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("rst_wec", 64'(wec1), 64'd0);
        chk("rst_locked", 64'(locked1), 64'd0);

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            logic v, c, r, rn;
            logic [31:0] x;
            v = ($urandom_range(0, 3) != 0);
            x = '0;
            if ($urandom_range(0, 15) == 0) x = 32'd1 << $urandom_range(0, 31);
            if ($urandom_range(0, 63) == 0) x = $urandom;
            c = ($urandom_range(0, 63) == 0);
            r = ($urandom_range(0, 127) == 0);
            rn = (i != 300);
            step(rn, v, gen_w ^ x, c, r);
            if (v) gen_w = prbs_next(gen_w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
